player_bullet_ctrl: RTL and testbench

Launches and flies the player's single bullet and reports its position and enable to the enemy hit-judge logic. It consumes the judge's hit pulse to retire the bullet. The block sits between the player input/position logic and the enemy collision judges, and it feeds the renderer with the bullet coordinates. The bullet has a three-state lifecycle: idle, in flight, and cooldown.

---
 rtl/game_pkg.sv | 22 ++
 rtl/rise_edge_det.sv | 34 +++
 rtl/player_bullet_ctrl.sv | 129 ++++++++++++
 tb/tb_player_bullet_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared screen geometry and bullet lifecycle state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        COOL = 2'd2
    } bullet_state_t;

endpackage

`default_nettype wire

// File: rtl/rise_edge_det.sv
// ============================================================================
// Module      : rise_edge_det
// Description : Single-cycle pulse on the rising edge of a synchronous level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic in_q;
    logic in_d;

    always_comb begin
        in_d = in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_d;
        end
    end

    assign pulse = in & ~in_q;

endmodule

`default_nettype wire

// File: rtl/player_bullet_ctrl.sv
// ============================================================================
// Module      : player_bullet_ctrl
// Description : Launches, flies and retires the player's single bullet.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_bullet_ctrl
    import game_pkg::*;
#(
    parameter int unsigned SPEED    = 4,
    parameter int unsigned X_OFFSET = 20,
    parameter int unsigned SPAWN_DY = 10,
    parameter int unsigned COOLDOWN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               move_tick,
    input  logic               fire,
    input  logic [COORD_W-1:0] p_x,
    input  logic [COORD_W-1:0] p_y,
    input  logic               hit,
    output logic [COORD_W-1:0] b_x,
    output logic [COORD_W-1:0] b_y,
    output logic               mybullet_en,
    output logic               busy,
    output logic [7:0]         shot_cnt
);

    localparam logic [COORD_W-1:0] c_speed    = SPEED[COORD_W-1:0];
    localparam logic [COORD_W-1:0] c_x_offset = X_OFFSET[COORD_W-1:0];
    localparam logic [COORD_W-1:0] c_spawn_dy = SPAWN_DY[COORD_W-1:0];
    localparam logic [7:0]         c_cooldown = COOLDOWN[7:0];

    bullet_state_t      state_q, state_d;
    logic [COORD_W-1:0] b_x_q, b_x_d;
    logic [COORD_W-1:0] b_y_q, b_y_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic [7:0]         shot_cnt_q, shot_cnt_d;
    logic [7:0]         cool_cnt_q, cool_cnt_d;
    logic               fire_rise;

    // Edge detection keeps a held button from auto-firing on return to IDLE.
    rise_edge_det u_fire_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (fire),
        .pulse (fire_rise)
    );

    always_comb begin
        state_d    = state_q;
        b_x_d      = b_x_q;
        b_y_d      = b_y_q;
        en_d       = en_q;
        shot_cnt_d = shot_cnt_q;
        cool_cnt_d = cool_cnt_q;

        case (state_q)
            IDLE: begin
                if (fire_rise) begin
                    b_x_d      = p_x + c_x_offset;
                    b_y_d      = (p_y >= c_spawn_dy) ? (p_y - c_spawn_dy) : '0;
                    en_d       = 1'b1;
                    shot_cnt_d = shot_cnt_q + 8'd1;
                    state_d    = FLY;
                end
            end
            FLY: begin
                if (hit) begin
                    en_d       = 1'b0;
                    cool_cnt_d = 8'd0;
                    state_d    = COOL;
                end else if (move_tick) begin
                    if (b_y_q < c_speed) begin
                        en_d       = 1'b0;
                        cool_cnt_d = 8'd0;
                        state_d    = COOL;
                    end else begin
                        b_y_d = b_y_q - c_speed;
                    end
                end
            end
            COOL: begin
                if (cool_cnt_q == c_cooldown) begin
                    state_d = IDLE;
                end else if (move_tick) begin
                    cool_cnt_d = cool_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            b_x_q      <= '0;
            b_y_q      <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            shot_cnt_q <= 8'd0;
            cool_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            b_x_q      <= b_x_d;
            b_y_q      <= b_y_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            shot_cnt_q <= shot_cnt_d;
            cool_cnt_q <= cool_cnt_d;
        end
    end

    assign b_x         = b_x_q;
    assign b_y         = b_y_q;
    assign mybullet_en = en_q;
    assign busy        = busy_q;
    assign shot_cnt    = shot_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_player_bullet_ctrl.sv
// ============================================================================
// Module      : tb_player_bullet_ctrl
// Description : Directed self-checking bench for player_bullet_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_player_bullet_ctrl;

    logic       clk;
    logic       rst;
    logic       move_tick;
    logic       fire;
    logic [9:0] p_x;
    logic [9:0] p_y;
    logic       hit;
    logic [9:0] b_x;
    logic [9:0] b_y;
    logic       mybullet_en;
    logic       busy;
    logic [7:0] shot_cnt;

    int n_checks;
    int n_errors;

    player_bullet_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .move_tick   (move_tick),
        .fire        (fire),
        .p_x         (p_x),
        .p_y         (p_y),
        .hit         (hit),
        .b_x         (b_x),
        .b_y         (b_y),
        .mybullet_en (mybullet_en),
        .busy        (busy),
        .shot_cnt    (shot_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
    endtask

    task automatic press_fire();
        fire = 1'b1;
        step();
        fire = 1'b0;
    endtask

    task automatic do_hit();
        hit = 1'b1;
        step();
        hit = 1'b0;
    endtask

    task automatic wait_cool();
        repeat (8) do_tick();
        step();
        step();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        move_tick = 1'b0;
        fire      = 1'b0;
        hit       = 1'b0;
        p_x       = 10'd0;
        p_y       = 10'd0;
        #1;
        check_eq("rst_en",   32'(mybullet_en), 32'd0);
        check_eq("rst_busy", 32'(busy),        32'd0);
        check_eq("rst_shot", 32'(shot_cnt),    32'd0);
        check_eq("rst_bx",   32'(b_x),         32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Hit pulse while idle
        do_hit();
        check_eq("idle_hit_en",   32'(mybullet_en), 32'd0);
        check_eq("idle_hit_busy", 32'(busy),        32'd0);

        // Launch
        p_x = 10'd300;
        p_y = 10'd400;
        press_fire();
        check_eq("launch_en",   32'(mybullet_en), 32'd1);
        check_eq("launch_bx",   32'(b_x),         32'd320);
        check_eq("launch_by",   32'(b_y),         32'd390);
        check_eq("launch_shot", 32'(shot_cnt),    32'd1);
        check_eq("launch_busy", 32'(busy),        32'd1);
        repeat (3) do_tick();
        check_eq("fly_by", 32'(b_y), 32'd378);

        // Hit and cooldown with ignored presses
        do_hit();
        check_eq("hit_en",   32'(mybullet_en), 32'd0);
        check_eq("hit_by",   32'(b_y),         32'd378);
        check_eq("hit_busy", 32'(busy),        32'd1);
        for (int i = 0; i < 8; i++) begin
            do_tick();
            if (i < 7) begin
                press_fire();
                step();
            end
        end
        check_eq("cool_shot_ignored", 32'(shot_cnt), 32'd1);
        step();
        check_eq("cool_done_busy", 32'(busy), 32'd0);
        press_fire();
        check_eq("refire_shot", 32'(shot_cnt),    32'd2);
        check_eq("refire_en",   32'(mybullet_en), 32'd1);
        do_hit();
        wait_cool();

        // Off-screen retirement
        p_y = 10'd20;
        press_fire();
        check_eq("off_by0", 32'(b_y), 32'd10);
        do_tick();
        check_eq("off_by1", 32'(b_y), 32'd6);
        do_tick();
        check_eq("off_by2", 32'(b_y), 32'd2);
        do_tick();
        check_eq("off_en",   32'(mybullet_en), 32'd0);
        check_eq("off_by3",  32'(b_y),         32'd2);
        check_eq("off_busy", 32'(busy),        32'd1);
        wait_cool();

        // Simultaneous hit and move_tick
        p_y = 10'd210;
        press_fire();
        check_eq("sim_by0", 32'(b_y), 32'd200);
        hit       = 1'b1;
        move_tick = 1'b1;
        step();
        hit       = 1'b0;
        move_tick = 1'b0;
        check_eq("sim_en", 32'(mybullet_en), 32'd0);
        check_eq("sim_by", 32'(b_y),         32'd200);
        wait_cool();

        // Held fire through flight and cooldown
        fire = 1'b1;
        step();
        check_eq("held_shot0", 32'(shot_cnt), 32'd5);
        do_hit();
        wait_cool();
        repeat (3) step();
        check_eq("held_busy", 32'(busy),        32'd0);
        check_eq("held_en",   32'(mybullet_en), 32'd0);
        check_eq("held_shot", 32'(shot_cnt),    32'd5);
        fire = 1'b0;
        step();
        press_fire();
        check_eq("repress_shot", 32'(shot_cnt), 32'd6);
        do_hit();
        wait_cool();

        // Spawn saturation
        p_y = 10'd5;
        press_fire();
        check_eq("sat_by",   32'(b_y),         32'd0);
        check_eq("sat_en",   32'(mybullet_en), 32'd1);
        check_eq("sat_shot", 32'(shot_cnt),    32'd7);
        do_tick();
        check_eq("sat_retire_en",   32'(mybullet_en), 32'd0);
        check_eq("sat_retire_busy", 32'(busy),        32'd1);
        wait_cool();

        // Asynchronous reset mid-flight
        p_y = 10'd400;
        press_fire();
        check_eq("pre_rst_en", 32'(mybullet_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_en",   32'(mybullet_en), 32'd0);
        check_eq("arst_busy", 32'(busy),        32'd0);
        check_eq("arst_shot", 32'(shot_cnt),    32'd0);
        check_eq("arst_by",   32'(b_y),         32'd0);
        step();
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
